vga_timing: RTL and testbench
=============================

# vga_timing

Raster timing generator for the VGA output path. It keeps the horizontal and vertical pixel counters and produces `o_hpos`, `o_vpos` and `o_visible`, which feed the pixel-colour stages such as the test pattern generator. It also produces the sync and line/frame markers that go to the VGA connector and to frame-synchronous logic. Default timing is 640x480 at 60 Hz, with the 25 MHz board clock used as the pixel clock.

## Interface
- `H_VISIBLE`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync width, in pixels
- `H_BACK`, 48: horizontal back porch, in pixels
- `V_VISIBLE`, 480: active lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BACK`, 33: vertical back porch, in lines
- `SYNC_ACTIVE_LOW`, 1: 1 drives sync outputs 0 while in sync; 0 drives them 1
- `i_clk`  in  1  pixel/system clock; all state changes on the rising edge
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_pix_en`  in  1  pixel tick qualifier; tie high for one pixel per clock
- `o_hpos`  out  10  current column, 0..H_TOTAL-1
- `o_vpos`  out  10  current line, 0..V_TOTAL-1
- `o_visible`  out  1  current (hpos, vpos) is inside the active area
- `o_hsync`  out  1  horizontal sync, polarity set by SYNC_ACTIVE_LOW
- `o_vsync`  out  1  vertical sync, polarity set by SYNC_ACTIVE_LOW
- `o_line_start`  out  1  one-clock pulse when hpos becomes 0
- `o_frame_start`  out  1  one-clock pulse when (hpos, vpos) becomes (0, 0)

## Operation
- Derived constants:
  - H_TOTAL = sum of the four H parameters (800 by default).
  - V_TOTAL = sum of the four V parameters (525 by default).
  - Both totals must be ≤ 1024. The design does not check this; violating it is a configuration error.
- Counter update, only on a clock edge where `i_pix_en`=1:
  - If hpos = H_TOTAL-1: hpos ← 0. Then if vpos = V_TOTAL-1, vpos ← 0; otherwise vpos ← vpos+1.
  - Otherwise: hpos ← hpos+1 and vpos is unchanged.
- Every output is registered and is a pure function of the counter value it is reported with. Each output changes on the same edge as the counters, so there is zero skew between them.
  - `o_visible` = (hpos < H_VISIBLE) && (vpos < V_VISIBLE).
  - Horizontal sync is active for hpos in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]. Default: 656..751.
  - Vertical sync is active for vpos in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]. Default: 490..491. Vsync is decided by vpos alone, for the whole line.
  - `o_line_start` = 1 on the clock cycle immediately after an enabled edge that loaded hpos = 0. It is 0 on every other cycle, including when `i_pix_en` is low.
  - `o_frame_start` = same rule as `o_line_start`, for a load of (0, 0).
- When `i_pix_en`=0: counters, `o_visible` and the syncs hold their values; both pulse outputs are 0.
- Next-state comparisons use the next counter values, so the outputs are not delayed by a pipeline stage.

## Timing
- Reset (asynchronous, while `i_rst_n`=0):
  - hpos = H_TOTAL-1 (799), vpos = V_TOTAL-1 (524).
  - `o_visible`=0. Syncs inactive (1 when SYNC_ACTIVE_LOW=1).
  - `o_line_start`=0, `o_frame_start`=0.
- First enabled edge after reset release: counters go to (0, 0), `o_visible`=1, and both pulses are 1 for that one cycle. Every frame therefore starts cleanly at the origin.
- Reset asserted mid-frame: all outputs take their reset values immediately, without waiting for a clock edge. The frame in progress is abandoned and no partial pulse is produced.
- Frame period with `i_pix_en`=1 is H_TOTAL×V_TOTAL = 420000 clocks. The line period is 800 clocks.
- Downstream colour logic that registers its output adds its own latency. This block gives no compensation for it.

## Test plan
- Reset: hold `i_rst_n`=0 and toggle the clock → hpos=799, vpos=524, visible=0, hsync=vsync=1, both pulses 0. Assert reset mid-line (hpos=300) → outputs return to these values before the next clock edge.
- Release reset, then first edge with `i_pix_en`=1 → (0, 0), visible=1, line_start=1 and frame_start=1 for exactly one cycle. Next edge → (1, 0), both pulses 0.
- Horizontal sweep on line 0:
  - hpos 639 → visible=1; hpos 640 → visible=0.
  - hsync low exactly for hpos 656..751 (96 clocks).
  - Edge after hpos 799 → hpos=0, vpos=1, line_start=1, frame_start=0.
- Vertical: vsync low for every clock of lines 490 and 491, and high at (799, 489) and (0, 492). visible=0 for all of lines 480..524. Edge after (799, 524) → (0, 0) with frame_start=1.
- `i_pix_en` gating: drive 1,0,0,1 from (10, 5) → outputs hold at (11, 5) during the two low cycles, then go to (12, 5). No pulse occurs while enable is low.
- Frame count with `i_pix_en`=1: exactly 420000 clocks between successive frame_start pulses, 525 line_start pulses per frame, and 307200 visible clocks per frame. Repeat with SYNC_ACTIVE_LOW=0 → sync outputs are inverted and all other outputs are identical.

Source files
------------

// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel-enable input and raster timing outputs of the VGA timing generator.
interface vga_timing_if;
  logic       i_pix_en;
  logic [9:0] o_hpos;
  logic [9:0] o_vpos;
  logic       o_visible;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_line_start;
  logic       o_frame_start;
  modport master (
    input  i_pix_en,
    output o_hpos, o_vpos, o_visible, o_hsync, o_vsync, o_line_start, o_frame_start
  );
  modport slave (
    output i_pix_en,
    input  o_hpos, o_vpos, o_visible, o_hsync, o_vsync, o_line_start, o_frame_start
  );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: raster counters with registered visible/sync/line/frame markers, all aligned to the counters.
module vga_timing #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input logic          i_clk,
  input logic          i_rst_n,
  vga_timing_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic       SYNC_IDLE = SYNC_ACTIVE_LOW != 0;
  logic [9:0] hpos_q, hpos_d, vpos_q, vpos_d, hpos_n, vpos_n;
  logic       visible_q, visible_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic       line_start_q, line_start_d, frame_start_q, frame_start_d, h_wrap;
  // Outputs are decoded from the next counter values so they land on the same edge as the counters.
  always_comb begin
    h_wrap        = hpos_q == H_LAST;
    hpos_n        = h_wrap ? '0 : hpos_q + 10'd1;
    vpos_n        = !h_wrap ? vpos_q : (vpos_q == V_LAST ? '0 : vpos_q + 10'd1);
    hpos_d        = vga.i_pix_en ? hpos_n : hpos_q;
    vpos_d        = vga.i_pix_en ? vpos_n : vpos_q;
    visible_d     = hpos_d < H_VIS && vpos_d < V_VIS;
    hsync_d       = SYNC_IDLE ^ (hpos_d >= HS_FIRST && hpos_d <= HS_LAST);
    vsync_d       = SYNC_IDLE ^ (vpos_d >= VS_FIRST && vpos_d <= VS_LAST);
    line_start_d  = vga.i_pix_en && h_wrap;
    frame_start_d = line_start_d && vpos_q == V_LAST;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      visible_q     <= 1'b0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      visible_q     <= visible_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign vga.o_hpos        = hpos_q;
  assign vga.o_vpos        = vpos_q;
  assign vga.o_visible     = visible_q;
  assign vga.o_hsync       = hsync_q;
  assign vga.o_vsync       = vsync_q;
  assign vga.o_line_start  = line_start_q;
  assign vga.o_frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: checks one default-timing and two small-timing instances against a linear-index raster model.
module tb_vga_timing;
  typedef struct {int hv, hf, hs, hb, vv, vf, vs, vb; bit low;} cfg_t;
  typedef struct packed {logic [9:0] h, v; logic vis, hs, vs, ls, fs;} out_t;
  bit   clk, rst_n, pix_en, run_cmp;
  int   n_vec, n_err;
  cfg_t cfg[3];
  int   mh[3], mv[3];
  bit   mls[3], mfs[3];
  vga_timing_if u0 (), u1 (), u2 ();
  assign u0.i_pix_en = pix_en;
  assign u1.i_pix_en = pix_en;
  assign u2.i_pix_en = pix_en;
  vga_timing d0 (.i_clk(clk), .i_rst_n(rst_n), .vga(u0.master));
  vga_timing #(.H_VISIBLE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4), .V_VISIBLE(12), .V_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE_LOW(1)) d1 (.i_clk(clk), .i_rst_n(rst_n), .vga(u1.master));
  vga_timing #(.H_VISIBLE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4), .V_VISIBLE(12), .V_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE_LOW(0)) d2 (.i_clk(clk), .i_rst_n(rst_n), .vga(u2.master));
  initial forever #5 clk = ~clk;
  function automatic int htot(int k);
    return cfg[k].hv + cfg[k].hf + cfg[k].hs + cfg[k].hb;
  endfunction
  function automatic int vtot(int k);
    return cfg[k].vv + cfg[k].vf + cfg[k].vs + cfg[k].vb;
  endfunction
  function automatic out_t model_out(int k);
    out_t o;
    int hs0 = cfg[k].hv + cfg[k].hf;
    int vs0 = cfg[k].vv + cfg[k].vf;
    o.h   = 10'(mh[k]);
    o.v   = 10'(mv[k]);
    o.vis = mh[k] < cfg[k].hv && mv[k] < cfg[k].vv;
    o.hs  = cfg[k].low ^ (mh[k] >= hs0 && mh[k] < hs0 + cfg[k].hs);
    o.vs  = cfg[k].low ^ (mv[k] >= vs0 && mv[k] < vs0 + cfg[k].vs);
    o.ls  = mls[k];
    o.fs  = mfs[k];
    return o;
  endfunction
  function automatic out_t dut_out(int k);
    out_t o;
    case (k)
      0: o = '{u0.o_hpos, u0.o_vpos, u0.o_visible, u0.o_hsync, u0.o_vsync, u0.o_line_start, u0.o_frame_start};
      1: o = '{u1.o_hpos, u1.o_vpos, u1.o_visible, u1.o_hsync, u1.o_vsync, u1.o_line_start, u1.o_frame_start};
      default: o = '{u2.o_hpos, u2.o_vpos, u2.o_visible, u2.o_hsync, u2.o_vsync, u2.o_line_start, u2.o_frame_start};
    endcase
    return o;
  endfunction
  // Model position is a linear pixel index within the frame; pulses mark a wrap of that index.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mh[k] = htot(k) - 1;
        mv[k] = vtot(k) - 1;
        mls[k] = 0;
        mfs[k] = 0;
      end else if (pix_en) begin
        int lin = (mv[k] * htot(k) + mh[k] + 1) % (htot(k) * vtot(k));
        mh[k] = lin % htot(k);
        mv[k] = lin / htot(k);
        mls[k] = mh[k] == 0;
        mfs[k] = lin == 0;
      end else begin
        mls[k] = 0;
        mfs[k] = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (run_cmp) begin
      for (int k = 0; k < 3; k++) begin
        out_t g = dut_out(k);
        out_t e = model_out(k);
        n_vec++;
        if (g !== e) begin
          n_err++;
          $display("FAIL model dut%0d got h=%0d v=%0d vis=%b hs=%b vs=%b ls=%b fs=%b expected h=%0d v=%0d vis=%b hs=%b vs=%b ls=%b fs=%b",
            k, g.h, g.v, g.vis, g.hs, g.vs, g.ls, g.fs, e.h, e.v, e.vis, e.hs, e.vs, e.ls, e.fs);
        end
      end
    end
  end
  task automatic check(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check_reset0(string tag);
    check({tag, "_hpos"}, u0.o_hpos, 799);
    check({tag, "_vpos"}, u0.o_vpos, 524);
    check({tag, "_vis"}, u0.o_visible, 0);
    check({tag, "_hsync"}, u0.o_hsync, 1);
    check({tag, "_vsync"}, u0.o_vsync, 1);
    check({tag, "_ls"}, u0.o_line_start, 0);
    check({tag, "_fs"}, u0.o_frame_start, 0);
  endtask
  initial begin
    int cnt, w, per, ls1, vis1, hs1, hs2;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1};
    cfg[1] = '{20, 3, 5, 4, 12, 2, 2, 3, 1'b1};
    cfg[2] = '{20, 3, 5, 4, 12, 2, 2, 3, 1'b0};
    rst_n = 0;
    pix_en = 1;
    run_cmp = 1;
    tick(3);
    check_reset0("rst");
    rst_n = 1;
    tick(1);
    check("first_hpos", u0.o_hpos, 0);
    check("first_vpos", u0.o_vpos, 0);
    check("first_vis", u0.o_visible, 1);
    check("first_ls", u0.o_line_start, 1);
    check("first_fs", u0.o_frame_start, 1);
    tick(1);
    check("second_hpos", u0.o_hpos, 1);
    check("second_ls", u0.o_line_start, 0);
    check("second_fs", u0.o_frame_start, 0);
    tick(638);
    check("h639_hpos", u0.o_hpos, 639);
    check("h639_vis", u0.o_visible, 1);
    tick(1);
    check("h640_vis", u0.o_visible, 0);
    cnt = int'(u0.o_hsync == 1'b0);
    for (int i = 0; i < 159; i++) begin
      tick(1);
      cnt += int'(u0.o_hsync == 1'b0);
    end
    check("line0_end_hpos", u0.o_hpos, 799);
    check("hsync_low_clocks", cnt, 96);
    tick(1);
    check("line1_hpos", u0.o_hpos, 0);
    check("line1_vpos", u0.o_vpos, 1);
    check("line1_ls", u0.o_line_start, 1);
    check("line1_fs", u0.o_frame_start, 0);
    tick(4 * 800 + 10);
    check("gate_start_hpos", u0.o_hpos, 10);
    check("gate_start_vpos", u0.o_vpos, 5);
    tick(1);
    pix_en = 0;
    tick(1);
    check("gate_hold1_hpos", u0.o_hpos, 11);
    check("gate_hold1_ls", u0.o_line_start, 0);
    tick(1);
    check("gate_hold2_hpos", u0.o_hpos, 11);
    pix_en = 1;
    tick(1);
    check("gate_resume_hpos", u0.o_hpos, 12);
    check("gate_resume_vpos", u0.o_vpos, 5);
    w = 0;
    while (!u1.o_frame_start && w < 1000) begin
      tick(1);
      w++;
    end
    check("small_fs_seen", u1.o_frame_start, 1);
    per = 0;
    ls1 = u1.o_line_start;
    vis1 = u1.o_visible;
    hs1 = int'(u1.o_hsync == 1'b0);
    hs2 = int'(u2.o_hsync == 1'b1);
    while (per < 2000) begin
      tick(1);
      per++;
      if (u1.o_frame_start) break;
      ls1 += u1.o_line_start;
      vis1 += u1.o_visible;
      hs1 += int'(u1.o_hsync == 1'b0);
      hs2 += int'(u2.o_hsync == 1'b1);
    end
    check("small_frame_period", per, 608);
    check("small_line_starts", ls1, 19);
    check("small_visible_clocks", vis1, 240);
    check("small_hsync_low_clocks", hs1, 95);
    check("small_hsync_high_active", hs2, 95);
    repeat (3000) begin
      pix_en = $urandom_range(0, 3) != 0;
      tick(1);
    end
    pix_en = 1;
    w = 0;
    while (u0.o_hpos != 10'd300 && w < 1000) begin
      tick(1);
      w++;
    end
    check("midline_reached", u0.o_hpos, 300);
    rst_n = 0;
    #2;
    check_reset0("async_rst");
    tick(2);
    rst_n = 1;
    tick(1);
    check("restart_hpos", u0.o_hpos, 0);
    check("restart_vpos", u0.o_vpos, 0);
    check("restart_fs0", u0.o_frame_start, 1);
    check("restart_fs1", u1.o_frame_start, 1);
    repeat (500) begin
      pix_en = $urandom_range(0, 3) != 0;
      tick(1);
    end
    run_cmp = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
